// File: rtl/anneal_sequencer.sv
// anneal_sequencer: host-side command sequencer for the replica array.
// Each iteration draws one random move per replica (xorshift32), loads the moves,
// runs the array, walks every replica through its distance/metropolis slot and
// finishes with a replica-exchange command alternating PREV/FOLW.

package anneal_pkg;
  typedef enum logic [1:0] {OR0 = 2'd0, OR1 = 2'd1, TWO = 2'd2} opt_command;
  typedef enum logic [1:0] {NOP = 2'd0, SELF = 2'd1, PREV = 2'd2, FOLW = 2'd3} exchange_command_t;
endpackage

module anneal_sequencer
  import anneal_pkg::*;
#(
  parameter int replica_num = 32,
  parameter int city_num    = 30,
  parameter int opt_wait    = 6,
  parameter int dist_wait   = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       iter_num,
  input  logic              seed_load,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              set_opt,
  output opt_command        opt_com,
  output logic [6:0]        K,
  output logic [6:0]        L,
  output logic              run_command,
  output exchange_command_t c_exchange,
  output logic              run_distance,
  output exchange_command_t c_metropolis
);

  localparam int REP_W   = (replica_num > 1) ? $clog2(replica_num) : 1;
  localparam int CNT_MAX = (dist_wait + 1 > opt_wait - 1) ? dist_wait + 1 : opt_wait - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, GEN, RUN, OWAIT, DIST, EXCH, FIN} state_t;

  typedef struct packed {
    opt_command com;
    logic [6:0] k;
    logic [6:0] l;
  } move_t;

  // One xorshift32 step.
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Map a raw generator word to a legal move; TWO moves are ordered K<L.
  function automatic move_t draw_move(input logic [31:0] r);
    logic [15:0] ka_m;
    logic [13:0] la_m;
    logic [6:0]  ka;
    logic [6:0]  la;
    move_t       m;
    ka_m = r[17:2] % 16'(city_num - 1);
    la_m = r[31:18] % 14'(city_num - 1);
    ka   = 7'(ka_m) + 7'd1;
    la   = 7'(la_m) + 7'd1;
    if (la == ka) la = (ka == 7'(city_num - 1)) ? 7'd1 : ka + 7'd1;
    case (r[1:0])
      2'd0:    m.com = OR0;
      2'd1:    m.com = OR1;
      default: m.com = TWO;
    endcase
    if (m.com == TWO && ka > la) begin
      m.k = la;
      m.l = ka;
    end else begin
      m.k = ka;
      m.l = la;
    end
    return m;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        gen_q, gen_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        iter_q, iter_d;
  logic [15:0]        iter_num_q, iter_num_d;
  move_t              hold_q, hold_d;
  move_t              mv_q [replica_num];
  move_t              gen_mv;
  move_t              out_mv;
  logic               mv_we;

  assign gen_mv  = draw_move(gen_q);
  assign opt_com = out_mv.com;
  assign K       = out_mv.k;
  assign L       = out_mv.l;

  // Next-state, counters, generator and strobe decode.
  always_comb begin
    state_d      = state_q;
    gen_d        = gen_q;
    rep_d        = rep_q;
    cnt_d        = cnt_q;
    iter_d       = iter_q;
    iter_num_d   = iter_num_q;
    out_mv       = hold_q;
    mv_we        = 1'b0;
    busy         = (state_q != IDLE) && (state_q != FIN);
    done         = 1'b0;
    set_opt      = 1'b0;
    run_command  = 1'b0;
    run_distance = 1'b0;
    c_exchange   = NOP;
    c_metropolis = NOP;
    case (state_q)
      IDLE: begin
        // Seed is applied before start so the first GEN uses it.
        if (seed_load) gen_d = (seed == 32'd0) ? 32'd1 : seed;
        if (start) begin
          iter_num_d = iter_num;
          iter_d     = '0;
          rep_d      = '0;
          cnt_d      = '0;
          state_d    = (iter_num == 16'd0) ? FIN : GEN;
        end
      end
      GEN: begin
        set_opt = 1'b1;
        out_mv  = gen_mv;
        mv_we   = 1'b1;
        gen_d   = xorshift32(gen_q);
        if (rep_q == REP_W'(replica_num - 1)) begin
          rep_d   = '0;
          state_d = RUN;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      RUN: begin
        run_command = 1'b1;
        cnt_d       = '0;
        state_d     = OWAIT;
      end
      OWAIT: begin
        if (cnt_q == CNT_W'(opt_wait - 1)) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = DIST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIST: begin
        out_mv = mv_q[rep_q];
        if (cnt_q == '0) run_distance = 1'b1;
        if (cnt_q == CNT_W'(dist_wait + 1)) begin
          c_metropolis = SELF;
          cnt_d        = '0;
          if (rep_q == REP_W'(replica_num - 1)) begin
            state_d = EXCH;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXCH: begin
        run_command = 1'b1;
        c_exchange  = iter_q[0] ? FOLW : PREV;
        iter_d      = iter_q + 16'd1;
        rep_d       = '0;
        state_d     = (iter_d == iter_num_q) ? FIN : GEN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hold_d = out_mv;
  end

  // Control and held-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gen_q      <= 32'd1;
      rep_q      <= '0;
      cnt_q      <= '0;
      iter_q     <= '0;
      iter_num_q <= '0;
      hold_q     <= '{com: OR0, k: 7'd0, l: 7'd0};
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      iter_num_q <= iter_num_d;
      hold_q     <= hold_d;
    end
  end

  // Move store written during GEN, read back during DIST.
  always_ff @(posedge clk) begin
    if (mv_we) mv_q[rep_q] <= gen_mv;
  end

endmodule

// File: tb/tb_anneal_sequencer.sv
// Testbench for anneal_sequencer: position-in-run reference model plus literal pins.
module tb_anneal_sequencer;
  import anneal_pkg::*;

  localparam int RN    = 32;
  localparam int CN    = 30;
  localparam int OW    = 6;
  localparam int DW    = 21;
  localparam int SLOT  = DW + 2;
  localparam int DIST0 = RN + 1 + OW;
  localparam int ILEN  = RN + 1 + OW + RN * SLOT + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic seed_load = 1'b0;
  logic [15:0] iter_num = '0;
  logic [31:0] seed = '0;
  logic busy, done, set_opt, run_command, run_distance;
  opt_command opt_com;
  logic [6:0] K, L;
  exchange_command_t c_exchange, c_metropolis;

  anneal_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .iter_num(iter_num),
    .seed_load(seed_load), .seed(seed), .busy(busy), .done(done),
    .set_opt(set_opt), .opt_com(opt_com), .K(K), .L(L),
    .run_command(run_command), .c_exchange(c_exchange),
    .run_distance(run_distance), .c_metropolis(c_metropolis)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int com; int k; int l; } mv_t;
  typedef struct { int busy; int done; int set; int run; int rd; int ex; int met; int com; int k; int l; } exp_t;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y ^= y << 13;
    y ^= y >> 17;
    y ^= y << 5;
    return y;
  endfunction

  function automatic mv_t draw(input logic [31:0] r);
    mv_t m;
    int a, b, t;
    logic [31:0] fa, fb;
    fa = {16'd0, r[17:2]};
    fb = {18'd0, r[31:18]};
    a = 1 + int'(fa) % (CN - 1);
    b = 1 + int'(fb) % (CN - 1);
    if (b == a) b = (a + 1 == CN) ? 1 : a + 1;
    m.com = (r[1:0] == 2'd0) ? 0 : (r[1:0] == 2'd1) ? 1 : 2;
    if (m.com == 2 && a > b) begin t = a; a = b; b = t; end
    m.k = a;
    m.l = b;
    return m;
  endfunction

  // Reference model state: whether a run is active and the cycle offset inside it.
  bit          m_run = 1'b0;
  bit          m_fin = 1'b0;
  int          m_off = 0;
  int          m_total = 0;
  logic [31:0] m_gen = 32'd1;
  mv_t         mv [RN];
  int          h_com = 0, h_k = 0, h_l = 0;

  function automatic exp_t expect_now();
    exp_t e;
    mv_t  g;
    int   pos, it, d;
    e = '{busy: int'(m_run), done: int'(m_fin), set: 0, run: 0, rd: 0, ex: int'(NOP),
          met: int'(NOP), com: h_com, k: h_k, l: h_l};
    if (m_run) begin
      pos = (m_off - 1) % ILEN;
      it  = (m_off - 1) / ILEN;
      if (pos < RN) begin
        g = draw(m_gen);
        e.set = 1; e.com = g.com; e.k = g.k; e.l = g.l;
      end else if (pos == RN) begin
        e.run = 1;
      end else if (pos >= DIST0 && pos < ILEN - 1) begin
        d = pos - DIST0;
        e.com = mv[d / SLOT].com; e.k = mv[d / SLOT].k; e.l = mv[d / SLOT].l;
        if (d % SLOT == 0) e.rd = 1;
        if (d % SLOT == SLOT - 1) e.met = int'(SELF);
      end else if (pos == ILEN - 1) begin
        e.run = 1;
        e.ex  = (it % 2 == 0) ? int'(PREV) : int'(FOLW);
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int pos;
    if (reset) begin
      m_run = 0; m_fin = 0; m_gen = 32'd1; h_com = 0; h_k = 0; h_l = 0;
    end else begin
      e = expect_now();
      h_com = e.com; h_k = e.k; h_l = e.l;
      if (m_run) begin
        pos = (m_off - 1) % ILEN;
        if (pos < RN) begin
          mv[pos] = draw(m_gen);
          m_gen = xs(m_gen);
        end
      end
      if (m_fin) m_fin = 0;
      else if (m_run) begin
        if (m_off == m_total) begin m_run = 0; m_fin = 1; end
        else m_off++;
      end else begin
        if (seed_load) m_gen = (seed == 32'd0) ? 32'd1 : seed;
        if (start) begin
          if (iter_num == 16'd0) m_fin = 1;
          else begin m_run = 1; m_off = 1; m_total = int'(iter_num) * ILEN; end
        end
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;
  int n_set, n_run, n_rd, n_met, last_rd, start_cyc;
  int f_com, f_k, f_l, s_com, s_k, s_l;
  int ex_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_counts();
    n_set = 0; n_run = 0; n_rd = 0; n_met = 0; last_rd = -1000;
    f_com = -1; f_k = -1; f_l = -1; s_com = -1; s_k = -1; s_l = -1;
    ex_q.delete();
  endtask

  // Cycle-by-cycle comparison against the model, plus pulse bookkeeping.
  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e = expect_now();
        chk("busy", int'(busy), e.busy);
        chk("done", int'(done), e.done);
        chk("set_opt", int'(set_opt), e.set);
        chk("run_command", int'(run_command), e.run);
        chk("run_distance", int'(run_distance), e.rd);
        chk("c_exchange", int'(c_exchange), e.ex);
        chk("c_metropolis", int'(c_metropolis), e.met);
        chk("opt_com", int'(opt_com), e.com);
        chk("K", int'(K), e.k);
        chk("L", int'(L), e.l);
        if (set_opt) begin
          if (n_set == 0) begin f_com = int'(opt_com); f_k = int'(K); f_l = int'(L); end
          if (n_set == 1) begin s_com = int'(opt_com); s_k = int'(K); s_l = int'(L); end
          n_set++;
          chk("K_range", int'(K >= 7'd1 && K <= 7'(CN - 1)), 1);
          chk("L_range", int'(L >= 7'd1 && L <= 7'(CN - 1)), 1);
          chk("K_ne_L", int'(K != L), 1);
          chk("two_order", int'(opt_com != TWO || K < L), 1);
        end
        if (run_command) begin
          n_run++;
          if (c_exchange != NOP) ex_q.push_back(int'(c_exchange));
        end
        if (run_distance) begin n_rd++; last_rd = cyc; end
        if (c_metropolis == SELF) begin
          n_met++;
          chk("met_after_rd", cyc - last_rd, DW + 1);
        end
      end
    end
  endtask

  task automatic run(input int it, input bit ld, input logic [31:0] sd, input int noise_at, output int lat);
    @(negedge clk);
    start = 1'b1; iter_num = 16'(it); seed_load = ld; seed = sd;
    start_cyc = cyc;
    clr_counts();
    lat = -1;
    for (int i = 0; i < it * ILEN + 50; i++) begin
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      if (i == noise_at) begin
        start = 1'b1; iter_num = 16'd5; seed_load = 1'b1; seed = $urandom;
      end
      if (done) begin lat = cyc - start_cyc; break; end
    end
    start = 1'b0; seed_load = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic main();
    int lat, it, na;
    bit ld;
    logic [31:0] sd;
    clr_counts();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_K", int'(K), 0);
    chk("rst_com", int'(opt_com), int'(OR0));
    reset = 1'b0;

    run(1, 1'b1, 32'h1, -1, lat);
    chk("lat_iter1", lat, 777);
    chk("first_com", f_com, int'(OR1));
    chk("first_K", f_k, 1);
    chk("first_L", f_l, 2);
    chk("second_com", s_com, int'(OR1));
    chk("second_K", s_k, 27);
    chk("second_L", s_l, 2);
    chk("set_opt_count", n_set, 32);
    chk("run_cmd_count1", n_run, 2);
    chk("run_dist_count1", n_rd, 32);

    run(2, 1'b0, 32'h0, 300, lat);
    chk("lat_iter2", lat, 1553);
    chk("run_cmd_count2", n_run, 4);
    chk("run_dist_count2", n_rd, 64);
    chk("met_count2", n_met, 64);
    chk("exch_count", ex_q.size(), 2);
    if (ex_q.size() == 2) begin
      chk("exch0_prev", ex_q[0], int'(PREV));
      chk("exch1_folw", ex_q[1], int'(FOLW));
    end

    run(1, 1'b1, 32'h0, -1, lat);
    chk("seed0_lat", lat, 777);
    chk("seed0_com", f_com, int'(OR1));
    chk("seed0_K", f_k, 1);
    chk("seed0_L", f_l, 2);

    run(0, 1'b0, 32'h0, -1, lat);
    chk("zero_iter_lat", lat, 1);
    chk("zero_iter_set", n_set, 0);
    chk("zero_iter_run", n_run, 0);

    @(negedge clk);
    start = 1'b1; iter_num = 16'd1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - start_cyc < 1 + DIST0 + 5 * SLOT + 3) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_K", int'(K), 0);
    chk("mid_rst_L", int'(L), 0);
    chk("mid_rst_com", int'(opt_com), int'(OR0));
    chk("mid_rst_rd", int'(run_distance), 0);
    chk("mid_rst_met", int'(c_metropolis), int'(NOP));
    reset = 1'b0;
    run(1, 1'b0, 32'h0, -1, lat);
    chk("restart_lat", lat, 777);
    chk("restart_com", f_com, int'(OR1));
    chk("restart_K", f_k, 1);
    chk("restart_L", f_l, 2);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      it = $urandom_range(1, 3);
      ld = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      na = ($urandom_range(0, 1) == 1) ? $urandom_range(5, it * ILEN - 10) : -1;
      run(it, ld, sd, na, lat);
      chk("rand_lat", lat, it * ILEN + 1);
      chk("rand_set_count", n_set, it * RN);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      compare_loop();
      main();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
